// File: rtl/pipe_hazard_unit_pkg.sv
// Shared types and defaults for the pipeline hazard/forwarding controller.
package pipe_hazard_unit_pkg;

    localparam int PIPE_DEPTH_DEF = 3;
    localparam int LOAD_STAGE_DEF = 3;
    localparam int REG_AW_DEF     = 5;
    localparam int FWD_SEL_REG    = 0;

    typedef struct packed {
        logic                  valid;
        logic [REG_AW_DEF-1:0] rd;
        logic                  wen;
        logic                  is_load;
    } stage_rec_t;

endpackage

// File: rtl/pipe_rec_sreg.sv
// In-flight destination records, stage 1 (E) .. DEPTH (W); whole chain holds on freeze.
module pipe_rec_sreg
    import pipe_hazard_unit_pkg::*;
#(
    parameter int  DEPTH = PIPE_DEPTH_DEF,
    parameter type rec_t = stage_rec_t
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hold,
    input  rec_t             s1_in,
    output rec_t [DEPTH:1]   recs
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            recs <= '0;
        end else if (!hold) begin
            recs[1] <= s1_in;
            for (int s = 2; s <= DEPTH; s++)
                recs[s] <= recs[s-1];
        end
    end

endmodule

// File: rtl/pipe_hazard_unit.sv
// Hazard/forwarding controller for a PIPE_DEPTH-stage E..W pipeline.
// Define HAZARD_FWD_EN for forwarding + load-use stalls; default build is interlock-only.
module pipe_hazard_unit
    import pipe_hazard_unit_pkg::*;
#(
    parameter int PIPE_DEPTH = PIPE_DEPTH_DEF,
    parameter int LOAD_STAGE = LOAD_STAGE_DEF,
    parameter int REG_AW     = REG_AW_DEF,
    parameter int SEL_W      = $clog2(PIPE_DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              d_valid,
    input  logic [REG_AW-1:0] d_rs1,
    input  logic [REG_AW-1:0] d_rs2,
    input  logic              d_use_rs1,
    input  logic              d_use_rs2,
    input  logic [REG_AW-1:0] d_rd,
    input  logic              d_wen,
    input  logic              d_is_load,
    input  logic              redirect,
    input  logic              mem_busy,
    output logic              stall_d,
    output logic              freeze,
    output logic              d_rs1_sel,
    output logic              d_rs2_sel,
    output logic [SEL_W-1:0]  e_rs1_sel,
    output logic [SEL_W-1:0]  e_rs2_sel,
    output logic [REG_AW-1:0] w_rd,
    output logic              w_wen,
    output logic [31:0]       stall_cnt
);

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] rd;
        logic              wen;
        logic              is_load;
    } rec_t;

    rec_t [PIPE_DEPTH:1] recs;
    rec_t                s1_in;
    logic                issue, du1, du2;

    function automatic logic hit(rec_t r, logic [REG_AW-1:0] src);
        return r.valid & r.wen & (r.rd == src) & (src != '0);
    endfunction

    // Gated by rst so every output reads 0 while reset is held.
    assign freeze = mem_busy & ~rst;
    assign du1    = d_valid & d_use_rs1;
    assign du2    = d_valid & d_use_rs2;
    assign issue  = d_valid & ~stall_d & ~redirect;
    assign s1_in  = issue ? rec_t'{valid: 1'b1, rd: d_rd, wen: d_wen, is_load: d_is_load} : '0;

    pipe_rec_sreg #(.DEPTH(PIPE_DEPTH), .rec_t(rec_t)) u_sreg (
        .clk   (clk),
        .rst   (rst),
        .hold  (freeze),
        .s1_in (s1_in),
        .recs  (recs)
    );

    assign d_rs1_sel = du1 & hit(recs[PIPE_DEPTH], d_rs1);
    assign d_rs2_sel = du2 & hit(recs[PIPE_DEPTH], d_rs2);
    assign w_rd      = recs[PIPE_DEPTH].rd;
    assign w_wen     = recs[PIPE_DEPTH].valid & recs[PIPE_DEPTH].wen & ~freeze;

`ifdef HAZARD_FWD_EN
    logic [REG_AW-1:0] e_rs1, e_rs2;
    logic              e_use1, e_use2;
    logic [SEL_W-1:0]  y1, y2;
    logic              y1_ld, y2_ld;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            e_rs1  <= '0;
            e_rs2  <= '0;
            e_use1 <= 1'b0;
            e_use2 <= 1'b0;
        end else if (!freeze) begin
            e_rs1  <= issue ? d_rs1 : '0;
            e_rs2  <= issue ? d_rs2 : '0;
            e_use1 <= issue & d_use_rs1;
            e_use2 <= issue & d_use_rs2;
        end
    end

    // Scan oldest to youngest so the smallest matching stage wins.
    always_comb begin
        y1        = '0;
        y2        = '0;
        y1_ld     = 1'b0;
        y2_ld     = 1'b0;
        e_rs1_sel = SEL_W'(FWD_SEL_REG);
        e_rs2_sel = SEL_W'(FWD_SEL_REG);
        for (int s = PIPE_DEPTH; s >= 1; s--) begin
            if (hit(recs[s], d_rs1)) begin
                y1    = SEL_W'(s);
                y1_ld = recs[s].is_load;
            end
            if (hit(recs[s], d_rs2)) begin
                y2    = SEL_W'(s);
                y2_ld = recs[s].is_load;
            end
            if (s >= 2 && e_use1 && hit(recs[s], e_rs1)) e_rs1_sel = SEL_W'(s);
            if (s >= 2 && e_use2 && hit(recs[s], e_rs2)) e_rs2_sel = SEL_W'(s);
        end
        stall_d = (du1 & y1_ld & (int'(y1) + 1 < LOAD_STAGE)) |
                  (du2 & y2_ld & (int'(y2) + 1 < LOAD_STAGE));
    end
`else
    logic unused_ld;

    // Without forwarding, a dependent waits until its producer reaches W.
    always_comb begin
        stall_d = 1'b0;
        for (int s = 1; s < PIPE_DEPTH; s++)
            if ((du1 & hit(recs[s], d_rs1)) | (du2 & hit(recs[s], d_rs2)))
                stall_d = 1'b1;
    end

    always_comb begin
        unused_ld = (LOAD_STAGE > 0);
        for (int s = 1; s <= PIPE_DEPTH; s++)
            unused_ld = unused_ld ^ recs[s].is_load;
    end

    assign e_rs1_sel = SEL_W'(FWD_SEL_REG);
    assign e_rs2_sel = SEL_W'(FWD_SEL_REG);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            stall_cnt <= '0;
        else if (stall_d && !freeze && !redirect && stall_cnt != '1)
            stall_cnt <= stall_cnt + 32'd1;
    end

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Scoreboard bench for pipe_hazard_unit: directed hazard scenarios plus random traffic.
module tb_pipe_hazard_unit;

`ifdef HAZARD_FWD_EN
    localparam bit FWD = 1'b1;
    localparam int PD  = 5;
    localparam int LS  = 4;
`else
    localparam bit FWD = 1'b0;
    localparam int PD  = 3;
    localparam int LS  = 3;
`endif
    localparam int SW = $clog2(PD + 1);

    logic clk = 1'b0;
    logic rst;
    logic d_valid, d_use_rs1, d_use_rs2, d_wen, d_is_load, redirect, mem_busy;
    logic [4:0] d_rs1, d_rs2, d_rd, w_rd;
    logic stall_d, freeze, d_rs1_sel, d_rs2_sel, w_wen;
    logic [SW-1:0] e_rs1_sel, e_rs2_sel;
    logic [31:0] stall_cnt;

    always #5 clk = ~clk;

    pipe_hazard_unit #(.PIPE_DEPTH(PD), .LOAD_STAGE(LS)) dut (
        .clk(clk), .rst(rst), .d_valid(d_valid), .d_rs1(d_rs1), .d_rs2(d_rs2),
        .d_use_rs1(d_use_rs1), .d_use_rs2(d_use_rs2), .d_rd(d_rd), .d_wen(d_wen),
        .d_is_load(d_is_load), .redirect(redirect), .mem_busy(mem_busy),
        .stall_d(stall_d), .freeze(freeze), .d_rs1_sel(d_rs1_sel), .d_rs2_sel(d_rs2_sel),
        .e_rs1_sel(e_rs1_sel), .e_rs2_sel(e_rs2_sel), .w_rd(w_rd), .w_wen(w_wen),
        .stall_cnt(stall_cnt)
    );

    typedef struct packed {
        bit v; bit [4:0] rd; bit wen; bit ld; bit [4:0] rs1; bit u1; bit [4:0] rs2; bit u2;
    } din_t;

    typedef struct packed {
        logic stall; logic frz; logic d1; logic d2;
        logic [SW-1:0] e1; logic [SW-1:0] e2;
        logic [4:0] wrd; logic wwen; logic [31:0] cnt;
    } out_t;

    // Reference pipeline: one instruction slot per stage, E = slot 1, W = slot PD.
    typedef struct packed { bit v; bit [4:0] rd; bit wen; bit ld; } ins_t;
    ins_t         m [1:8];
    bit [4:0]     me_rs1, me_rs2;
    bit           me_u1, me_u2;
    longint       m_cnt;

    out_t exp_q[$];
    int   n_chk = 0, n_fail = 0;

    function automatic bit writes(int s, bit [4:0] r);
        return m[s].v && m[s].wen && m[s].rd == r && r != 0;
    endfunction

    function automatic int youngest(bit [4:0] r, int from);
        for (int s = from; s <= PD; s++) if (writes(s, r)) return s;
        return 0;
    endfunction

    function automatic bit blocks(bit use_r, bit [4:0] r);
        int p;
        if (!use_r) return 0;
        p = youngest(r, 1);
        if (p == 0) return 0;
        if (FWD) return m[p].ld && (p + 1 < LS);
        return p < PD;
    endfunction

    function automatic out_t model_out(din_t d, bit busy);
        out_t o;
        o.stall = blocks(d.v & d.u1, d.rs1) || blocks(d.v & d.u2, d.rs2);
        o.frz   = busy;
        o.d1    = d.v && d.u1 && writes(PD, d.rs1);
        o.d2    = d.v && d.u2 && writes(PD, d.rs2);
        o.e1    = (FWD && me_u1) ? SW'(youngest(me_rs1, 2)) : '0;
        o.e2    = (FWD && me_u2) ? SW'(youngest(me_rs2, 2)) : '0;
        o.wrd   = m[PD].rd;
        o.wwen  = m[PD].v && m[PD].wen && !busy;
        o.cnt   = m_cnt[31:0];
        return o;
    endfunction

    task automatic model_reset();
        for (int s = 1; s <= 8; s++) m[s] = '0;
        me_rs1 = 0; me_rs2 = 0; me_u1 = 0; me_u2 = 0; m_cnt = 0;
    endtask

    task automatic model_adv(din_t d, bit busy, bit redir, bit stall);
        bit take;
        if (busy) return;
        if (stall && !redir && m_cnt < 64'hFFFF_FFFF) m_cnt++;
        for (int s = PD; s >= 2; s--) m[s] = m[s-1];
        take = d.v && !stall && !redir;
        m[1]   = take ? ins_t'{1'b1, d.rd, d.wen, d.ld} : '0;
        me_rs1 = take ? d.rs1 : 5'd0;
        me_rs2 = take ? d.rs2 : 5'd0;
        me_u1  = take && d.u1;
        me_u2  = take && d.u2;
    endtask

    function automatic din_t mk(bit v, bit [4:0] rd, bit wen, bit ld,
                                bit [4:0] rs1, bit u1, bit [4:0] rs2, bit u2);
        din_t d;
        d = '{v, rd, wen, ld, rs1, u1 & v, rs2, u2 & v};
        return d;
    endfunction

    // Called just after a posedge: drive, predict, then advance the model across the next edge.
    task automatic step(input din_t d, input bit busy, input bit redir, output bit acc);
        out_t e;
        d_valid = d.v; d_rd = d.rd; d_wen = d.wen; d_is_load = d.ld;
        d_rs1 = d.rs1; d_use_rs1 = d.u1; d_rs2 = d.rs2; d_use_rs2 = d.u2;
        mem_busy = busy; redirect = redir;
        e = model_out(d, busy);
        exp_q.push_back(e);
        acc = d.v && !busy && !e.stall && !redir;
        @(posedge clk);
        model_adv(d, busy, redir, e.stall);
        #1;
    endtask

    task automatic issue(input din_t d, input int busy_from, input int busy_len);
        bit acc;
        for (int k = 0; k < 40; k++) begin
            step(d, (k >= busy_from && k < busy_from + busy_len), 1'b0, acc);
            if (acc) return;
        end
        n_chk++; n_fail++;
        $display("FAIL issue_timeout: instruction rd=%0d not accepted within 40 cycles (required acceptance)", d.rd);
    endtask

    task automatic nops(input int n);
        bit acc;
        for (int k = 0; k < n; k++) step('0, 1'b0, 1'b0, acc);
    endtask

    always @(negedge clk) begin
        out_t e, a;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = '{stall_d, freeze, d_rs1_sel, d_rs2_sel, e_rs1_sel, e_rs2_sel, w_rd, w_wen, stall_cnt};
            n_chk++;
            if (a !== e) begin
                n_fail++;
                $display("FAIL outputs @%0t: got stall=%0b frz=%0b dsel=%0b%0b esel=%0d/%0d w=%0d/%0b cnt=%0d, required stall=%0b frz=%0b dsel=%0b%0b esel=%0d/%0d w=%0d/%0b cnt=%0d",
                         $time, a.stall, a.frz, a.d1, a.d2, a.e1, a.e2, a.wrd, a.wwen, a.cnt,
                         e.stall, e.frz, e.d1, e.d2, e.e1, e.e2, e.wrd, e.wwen, e.cnt);
            end
        end
    end

    initial begin
        bit acc;
        din_t d;
        rst = 1'b1;
        d_valid = 0; d_rs1 = 0; d_rs2 = 0; d_use_rs1 = 0; d_use_rs2 = 0;
        d_rd = 0; d_wen = 0; d_is_load = 0; redirect = 0; mem_busy = 0;
        model_reset();
        @(posedge clk); #1;
        exp_q.push_back('0);
        @(posedge clk); #1;
        rst = 1'b0;

        // ALU producer then immediate consumer
        issue(mk(1, 5, 1, 0, 0, 0, 0, 0), 0, 0);
        issue(mk(1, 6, 1, 0, 5, 1, 1, 1), 0, 0);
        nops(PD + 1);

        // load-use
        issue(mk(1, 7, 1, 1, 0, 0, 0, 0), 0, 0);
        issue(mk(1, 8, 1, 0, 7, 1, 0, 1), 0, 0);
        nops(PD + 1);

        // load-use with memory back-pressure during the stall
        issue(mk(1, 7, 1, 1, 0, 0, 0, 0), 0, 0);
        issue(mk(1, 8, 1, 0, 7, 1, 0, 1), 1, 3);
        nops(PD + 1);

        // two producers of x9, then x0 producer/consumer
        issue(mk(1, 9, 1, 0, 0, 0, 0, 0), 0, 0);
        issue(mk(1, 9, 1, 0, 0, 0, 0, 0), 0, 0);
        issue(mk(1, 10, 1, 0, 9, 1, 9, 1), 0, 0);
        issue(mk(1, 0, 1, 0, 0, 0, 0, 0), 0, 0);
        issue(mk(1, 11, 1, 0, 0, 1, 0, 1), 0, 0);
        nops(PD + 1);

        // redirect coinciding with a load-use stall
        issue(mk(1, 7, 1, 1, 0, 0, 0, 0), 0, 0);
        step(mk(1, 8, 1, 0, 7, 1, 0, 0), 1'b0, 1'b1, acc);
        nops(PD + 1);

        // asynchronous reset in the middle of a stall
        issue(mk(1, 12, 1, 1, 0, 0, 0, 0), 0, 0);
        step(mk(1, 13, 1, 0, 12, 1, 0, 0), 1'b0, 1'b0, acc);
        d = mk(1, 13, 1, 0, 12, 1, 0, 0);
        d_valid = d.v; d_rs1 = d.rs1; d_use_rs1 = d.u1; d_rd = d.rd; d_wen = d.wen;
        rst = 1'b1;
        model_reset();
        exp_q.push_back('0);
        @(posedge clk); #1;
        rst = 1'b0;
        nops(PD + 1);

        for (int i = 0; i < 3000; i++) begin
            d.v   = ($urandom_range(0, 9) != 0);
            d.rd  = 5'($urandom_range(0, 7));
            d.wen = ($urandom_range(0, 3) != 0);
            d.ld  = ($urandom_range(0, 2) == 0);
            d.rs1 = 5'($urandom_range(0, 7));
            d.rs2 = 5'($urandom_range(0, 7));
            d.u1  = d.v & 1'($urandom_range(0, 1));
            d.u2  = d.v & 1'($urandom_range(0, 1));
            step(d, ($urandom_range(0, 7) == 0), ($urandom_range(0, 9) == 0), acc);
        end
        nops(2);

        repeat (2) @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            n_chk++; n_fail++;
            $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_unit.md
# pipe_hazard_unit

Parametrised pipeline hazard and forwarding controller for the RV64I core, replacing the fixed 5-stage hazard logic inside the controller. It tracks destination-register records for every in-flight instruction from E to W across a configurable pipeline depth. From those records it generates D- and E-stage forwarding selects, multi-cycle load-use stalls, flush bubbles and the register-file write control. It also applies a global freeze from data-memory back-pressure and keeps a stall performance counter.

## Interface
- PIPE_DEPTH, 3: stages from E (stage 1) to W (stage PIPE_DEPTH); range 2..8
- LOAD_STAGE, 3: first stage at which load data is forwardable; range 2..PIPE_DEPTH
- REG_AW, 5: register address width
- SEL_W, $clog2(PIPE_DEPTH+1): forwarding-select width
- clk  in  1  clock
- rst  in  1  reset; one clock, asynchronous, active-high
- d_valid  in  1  D holds a real instruction
- d_rs1, d_rs2  in  REG_AW  D source registers
- d_use_rs1, d_use_rs2  in  1  D actually reads rs1/rs2
- d_rd  in  REG_AW  D destination
- d_wen  in  1  D writes rd
- d_is_load  in  1  D is a LOAD
- redirect  in  1  E-stage branch/jump taken (kill D)
- mem_busy  in  1  data memory not ready; freeze pipeline
- stall_d  out  1  hold F/D, insert bubble into E
- freeze  out  1  hold all stage registers
- d_rs1_sel, d_rs2_sel  out  1  1 = take W write data in D
- e_rs1_sel, e_rs2_sel  out  SEL_W  0 = E register data; k = result of stage k (2..PIPE_DEPTH)
- w_rd  out  REG_AW  register-file write address
- w_wen  out  1  register-file write enable
- stall_cnt  out  32  count of stall cycles

## Operation
- Each stage record holds {valid, rd, wen, is_load}, plus E-stage rs1/rs2/use flags in stage 1.
- Advance:
  - If freeze: all records hold.
  - Else records shift by one stage.
  - Stage 1 loads D's fields only if d_valid & !stall_d & !redirect; otherwise it gets an invalid bubble.
- Producer match: a record at stage s matches source r if valid & wen & rd==r & r!=0. Only the youngest match (smallest s) counts.
- E forwarding: e_rsX_sel = the youngest matching stage s among 2..PIPE_DEPTH. If no match, or E does not use rsX, it is 0.
- D forwarding: d_rsX_sel = 1 if the W record matches and D uses rsX.
- Load-use stall:
  - Condition: D uses r, the youngest producer of r is at stage s, it is a load, and s+1 < LOAD_STAGE.
  - Effect: stall_d=1, so the stall lasts LOAD_STAGE-1-s cycles.
- freeze = mem_busy. freeze has priority: redirect and stall_d still evaluate, but no state changes.
- redirect and stall_d together: redirect wins; stall_d is still driven, and a bubble is inserted either way.
- w_rd/w_wen come from the W record: w_wen = valid & wen & !freeze.
- stall_cnt increments when stall_d & !freeze & !redirect, and saturates at 2^32-1.

## Timing
- Reset: all records invalid.
  - All outputs are 0: stall_d, freeze, every sel, w_rd, w_wen and stall_cnt.
  - An asynchronous reset mid-operation discards all in-flight records immediately.
- All sel/stall outputs are combinational from the current records and D inputs, valid in the same cycle.
- Records update on posedge clk.
- A non-load producer forwards in the cycle immediately after it leaves E: zero stall.
- A load issued at cycle t is forwardable to an immediately-dependent instruction at stage LOAD_STAGE. That gives LOAD_STAGE-2 stall cycles.
- freeze holding N cycles delays everything by exactly N cycles; no record is lost or duplicated.

## Configuration
- HAZARD_FWD_EN defined: forwarding and load-use stall behave as above.
- HAZARD_FWD_EN undefined: interlock-only.
  - e_rsX_sel is tied to 0.
  - stall_d=1 while any producer matching a used D source sits at stages 1..PIPE_DEPTH-1.
  - The W-to-D bypass (d_rsX_sel) remains.

## Structure
- The DEF package gains:
  - stage_rec_t typedef {valid, rd, wen, is_load}
  - FWD_SEL_REG=0 constant
  - a default PIPE_DEPTH/LOAD_STAGE constant pair
- Sub-module pipe_rec_sreg: a PIPE_DEPTH-entry shift register of stage_rec_t with hold (freeze) and a stage-1 bubble input.
- Match, priority, stall and counter logic stay in pipe_hazard_unit.

## Test plan
- PIPE_DEPTH=3, LOAD_STAGE=3: ADD x5 then SUB x6,x5,x1 -> e_rs1_sel=2 in SUB's E cycle, stall_d never asserted.
- PIPE_DEPTH=5, LOAD_STAGE=4: LD x7 then ADD x8,x7,x0 -> stall_d high 2 cycles, then e_rs1_sel=4; stall_cnt=2.
- Same as above with mem_busy held 3 cycles during the stall -> records frozen, stall_d persists, stall_cnt still ends at 2.
- Two producers of x9 at stages 2 and 3 -> e_rs1_sel=2 (youngest wins). A producer with rd=x0 -> sel=0.
- redirect asserted together with a load-use stall -> stage 1 gets a bubble, stall_cnt unchanged.
- Reset asserted mid-stall -> all outputs 0 immediately, no w_wen pulse for the in-flight instructions.
- HAZARD_FWD_EN undefined, PIPE_DEPTH=3: ADD x5 then a dependent instruction -> stall_d 2 cycles, then issues with d_rs1_sel=1.
